// File: rtl/bp_class_check_pkg.sv
// Shared branch-predictor constants: the call/return opcodes, the link
// register indices, and a link-register test helper.
package bp_class_check_pkg;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [4:0] REG_RA  = 5'd1;
  localparam logic [4:0] REG_T0  = 5'd5;

  function automatic logic is_link_reg(input logic [4:0] r);
    return (r == REG_RA) || (r == REG_T0);
  endfunction
endpackage

// File: rtl/config_pkg.sv
// Core configuration shared by the IFU blocks.
//   XLEN : datapath / PC width in bits.
package config_pkg;
  localparam int unsigned XLEN = 32;
endpackage

// File: rtl/bp_class_decode.sv
// Combinational call/return class decode of an (expanded) instruction.
//   instr : 32-bit instruction
//   call  : JAL/JALR writing a link register
//   ret   : JALR not writing a link register but reading one
// call and ret are mutually exclusive by construction.
module bp_class_decode
  import bp_class_check_pkg::*;
(
  input  logic [31:0] instr,
  output logic        call,
  output logic        ret
);
  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign rd          = instr[11:7];
  assign rs1         = instr[19:15];
  assign unused_bits = ^{instr[31:20], instr[14:12]};

  // A JALR with link rd is treated as a call even when rs1 is also a link
  // register; the pop half of a coroutine swap is not modelled.
  assign call = ((opcode == OP_JAL) || (opcode == OP_JALR)) && is_link_reg(rd);
  assign ret  = (opcode == OP_JALR) && !is_link_reg(rd) && is_link_reg(rs1);
endmodule

// File: rtl/flopenrc.sv
// Stage-register primitive with enable and synchronous clear.
//   clk, reset : clock, asynchronous active-high reset (clears q)
//   en         : load enable; when low the register holds
//   clear      : when enabled, loads zero instead of d
//   d, q       : data in / out
module flopenrc #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     q <= '0;
    else if (en) begin
      if (clear)   q <= '0;
      else         q <= d;
    end
  end
endmodule

// File: rtl/bp_class_check.sv
// Branch-predictor instruction-class checker (RAS producer side).
// Registers the BTB-predicted call/return class F->D, decodes the true class
// in D, flags mispredictions, pipelines the true class and link address into
// E and M, and counts committed return-class mispredictions.
//   clk, reset                 : clock, async active-high reset
//   StallD/E/M, FlushD/E/M     : per-stage stall and flush
//   BPReturnF, BPCallF         : BTB predicted class of the Fetch instruction
//   InstrD, CompressedD, PCD   : Decode instruction, 16-bit origin flag, PC
//   ReturnD, CallD             : true class in D (combinational)
//   BPReturnWrongD, BPCallWrongD : predicted vs true class mismatch in D
//   ReturnE, CallE, PCLinkE    : true class and link address in E
//   ReturnM, CallM             : true class in M
//   ReturnWrongCnt             : committed return-misprediction count (wraps)
module bp_class_check
  import bp_class_check_pkg::*;
#(
  parameter int unsigned XLEN      = config_pkg::XLEN,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 StallD,
  input  logic                 StallE,
  input  logic                 StallM,
  input  logic                 FlushD,
  input  logic                 FlushE,
  input  logic                 FlushM,
  input  logic                 BPReturnF,
  input  logic                 BPCallF,
  input  logic [31:0]          InstrD,
  input  logic                 CompressedD,
  input  logic [XLEN-1:0]      PCD,
  output logic                 ReturnD,
  output logic                 CallD,
  output logic                 BPReturnWrongD,
  output logic                 BPCallWrongD,
  output logic                 ReturnE,
  output logic                 CallE,
  output logic [XLEN-1:0]      PCLinkE,
  output logic                 ReturnM,
  output logic                 CallM,
  output logic [CNT_WIDTH-1:0] ReturnWrongCnt
);
  logic            BPReturnD;
  logic            BPCallD;
  logic [XLEN-1:0] PCLinkD;

  bp_class_decode u_decode (
    .instr (InstrD),
    .call  (CallD),
    .ret   (ReturnD)
  );

  flopenrc #(.WIDTH(2)) u_fd_reg (
    .clk   (clk),
    .reset (reset),
    .clear (FlushD),
    .en    (~StallD),
    .d     ({BPReturnF, BPCallF}),
    .q     ({BPReturnD, BPCallD})
  );

  assign BPReturnWrongD = BPReturnD ^ ReturnD;
  assign BPCallWrongD   = BPCallD ^ CallD;

  // Addition is modulo 2^XLEN so the link address wraps at the top of memory.
  assign PCLinkD = PCD + (CompressedD ? XLEN'(2) : XLEN'(4));

  flopenrc #(.WIDTH(XLEN + 2)) u_de_reg (
    .clk   (clk),
    .reset (reset),
    .clear (FlushE),
    .en    (~StallE),
    .d     ({ReturnD, CallD, PCLinkD}),
    .q     ({ReturnE, CallE, PCLinkE})
  );

  flopenrc #(.WIDTH(2)) u_em_reg (
    .clk   (clk),
    .reset (reset),
    .clear (FlushM),
    .en    (~StallM),
    .d     ({ReturnE, CallE}),
    .q     ({ReturnM, CallM})
  );

  // Counted only on the edge the D instruction actually enters E, so a
  // stalled misprediction is counted once and a flushed one never.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ReturnWrongCnt <= '0;
    else if (BPReturnWrongD && !StallE && !FlushE)
      ReturnWrongCnt <= ReturnWrongCnt + CNT_WIDTH'(1);
  end
endmodule

// File: tb/tb_bp_class_check.sv
module tb_bp_class_check;
  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 4;

  localparam logic [31:0] I_NOP      = 32'h0000_0013;
  localparam logic [31:0] I_JAL_RA   = 32'h0080_00EF; // jal x1,+8
  localparam logic [31:0] I_RET      = 32'h0000_8067; // jalr x0,0(x1)
  localparam logic [31:0] I_JALR_T0  = 32'h0000_82E7; // jalr x5,0(x1)
  localparam logic [31:0] I_JALR_X6  = 32'h0003_0067; // jalr x0,0(x6)

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic StallD = 0, StallE = 0, StallM = 0, FlushD = 0, FlushE = 0, FlushM = 0;
  logic BPReturnF = 0, BPCallF = 0, CompressedD = 0;
  logic [31:0] InstrD = '0;
  logic [XLEN-1:0] PCD = '0;
  logic ReturnD, CallD, BPReturnWrongD, BPCallWrongD, ReturnE, CallE, ReturnM, CallM;
  logic [XLEN-1:0] PCLinkE;
  logic [CW-1:0] ReturnWrongCnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bp_class_check #(.XLEN(XLEN), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .BPReturnF(BPReturnF), .BPCallF(BPCallF),
    .InstrD(InstrD), .CompressedD(CompressedD), .PCD(PCD),
    .ReturnD(ReturnD), .CallD(CallD),
    .BPReturnWrongD(BPReturnWrongD), .BPCallWrongD(BPCallWrongD),
    .ReturnE(ReturnE), .CallE(CallE), .PCLinkE(PCLinkE),
    .ReturnM(ReturnM), .CallM(CallM), .ReturnWrongCnt(ReturnWrongCnt)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    bit          ret;
    bit          call;
    bit [XLEN-1:0] link;
  } slot_t;

  bit    m_pred_ret, m_pred_call;
  slot_t m_e, m_m;
  int unsigned m_cnt;

  function automatic bit link_reg(input bit [4:0] r);
    return r == 5'd1 || r == 5'd5;
  endfunction

  function automatic bit is_call(input bit [31:0] i);
    return (i[6:0] == 7'h6F || i[6:0] == 7'h67) && link_reg(i[11:7]);
  endfunction

  function automatic bit is_ret(input bit [31:0] i);
    return i[6:0] == 7'h67 && !link_reg(i[11:7]) && link_reg(i[19:15]);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pred_ret = 0; m_pred_call = 0;
      m_e = '{0, 0, 0}; m_m = '{0, 0, 0};
      m_cnt = 0;
    end else begin
      slot_t d;
      d.ret  = is_ret(InstrD);
      d.call = is_call(InstrD);
      d.link = XLEN'(longint'(PCD) + (CompressedD ? 2 : 4));
      if ((m_pred_ret != d.ret) && !StallE && !FlushE) m_cnt = (m_cnt + 1) % (1 << CW);
      if (!StallM) m_m = FlushM ? '{0, 0, 0} : '{m_e.ret, m_e.call, 0};
      if (!StallE) m_e = FlushE ? '{0, 0, 0} : d;
      if (!StallD) begin
        m_pred_ret  = FlushD ? 0 : BPReturnF;
        m_pred_call = FlushD ? 0 : BPCallF;
      end
    end
  end

  always @(negedge clk) begin
    check("ReturnD", ReturnD, is_ret(InstrD));
    check("CallD", CallD, is_call(InstrD));
    check("BPReturnWrongD", BPReturnWrongD, m_pred_ret != is_ret(InstrD));
    check("BPCallWrongD", BPCallWrongD, m_pred_call != is_call(InstrD));
    check("ReturnE", ReturnE, m_e.ret);
    check("CallE", CallE, m_e.call);
    check("PCLinkE", PCLinkE, m_e.link);
    check("ReturnM", ReturnM, m_m.ret);
    check("CallM", CallM, m_m.call);
    check("ReturnWrongCnt", ReturnWrongCnt, m_cnt);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(3))
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd5;
      default: return 5'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    i = $urandom;
    case ($urandom_range(2))
      0: i[6:0] = 7'h6F;
      1: i[6:0] = 7'h67;
      default: ;
    endcase
    i[11:7]  = pick_reg();
    i[19:15] = pick_reg();
    return i;
  endfunction

  initial begin
    step(); step();
    reset = 0;
    // reset state
    #1;
    check("rst_ReturnE", ReturnE, 0);
    check("rst_PCLinkE", PCLinkE, 0);
    check("rst_CallM", CallM, 0);
    check("rst_cnt", ReturnWrongCnt, 0);

    // jal x1,+8 at 0x1000
    InstrD = I_JAL_RA; PCD = 32'h1000; CompressedD = 0;
    #1 check("t1_CallD", CallD, 1);
    step(); InstrD = I_NOP;
    check("t1_CallE", CallE, 1);
    check("t1_PCLinkE", PCLinkE, 32'h1004);
    step();
    check("t1_CallM", CallM, 1);

    // compressed return at 0x2002, not predicted
    InstrD = I_RET; CompressedD = 1; PCD = 32'h2002;
    #1 check("t2_ReturnD", ReturnD, 1);
    check("t2_BPReturnWrongD", BPReturnWrongD, 1);
    step(); InstrD = I_NOP; CompressedD = 0;
    check("t2_ReturnE", ReturnE, 1);
    check("t2_PCLinkE", PCLinkE, 32'h2004);
    check("t2_cnt", ReturnWrongCnt, 1);

    // jalr x5,0(x1) is a call; jalr x0,0(x6) is neither
    InstrD = I_JALR_T0; BPCallF = 1;
    #1 check("t3_CallD", CallD, 1);
    check("t3_ReturnD", ReturnD, 0);
    step(); InstrD = I_JALR_X6; BPCallF = 0;
    #1 check("t3b_CallD", CallD, 0);
    check("t3b_ReturnD", ReturnD, 0);
    check("t3b_BPCallWrongD", BPCallWrongD, 1);
    step(); InstrD = I_NOP; step();

    // mispredicted return held in D by StallE for 3 cycles
    InstrD = I_RET; StallD = 1; StallE = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_ReturnE_held", ReturnE, 0);
      check("t4_cnt_held", ReturnWrongCnt, 1);
    end
    StallD = 0; StallE = 0;
    step(); InstrD = I_NOP;
    check("t4_ReturnE", ReturnE, 1);
    check("t4_cnt", ReturnWrongCnt, 2);

    // flushed return
    InstrD = I_RET; CompressedD = 1; PCD = 32'h3000; FlushE = 1;
    step(); FlushE = 0; InstrD = I_NOP; CompressedD = 0;
    check("t5_ReturnE", ReturnE, 0);
    check("t5_PCLinkE", PCLinkE, 0);
    check("t5_cnt", ReturnWrongCnt, 2);

    // counter wrap
    reset = 1; step(); reset = 0;
    InstrD = I_RET; PCD = 32'hFFFF_FFFE; CompressedD = 1;
    for (int i = 1; i <= 21; i++) begin
      step();
      if (i == 1)  check("t6_PCLinkE_wrap", PCLinkE, 32'h0);
      if (i == 15) check("t6_cnt_allones", ReturnWrongCnt, 4'hF);
      if (i == 16) check("t6_cnt_wrap", ReturnWrongCnt, 0);
    end
    check("t6_cnt5", ReturnWrongCnt, 5);

    // asynchronous reset mid-pipeline
    InstrD = I_JAL_RA; CompressedD = 0;
    step(); InstrD = I_NOP;
    check("t7_CallE_pre", CallE, 1);
    check("t7_cnt_pre", ReturnWrongCnt, 5);
    #3 reset = 1;
    #1;
    check("t7_CallE", CallE, 0);
    check("t7_PCLinkE", PCLinkE, 0);
    check("t7_ReturnM", ReturnM, 0);
    check("t7_cnt", ReturnWrongCnt, 0);
    step(); reset = 0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      InstrD      = rand_instr();
      CompressedD = 1'($urandom);
      PCD         = ($urandom_range(7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(3))) : $urandom;
      BPReturnF   = ($urandom_range(3) == 0);
      BPCallF     = ($urandom_range(3) == 0);
      StallD      = ($urandom_range(5) == 0);
      StallE      = ($urandom_range(5) == 0);
      StallM      = ($urandom_range(7) == 0);
      FlushD      = ($urandom_range(7) == 0);
      FlushE      = ($urandom_range(7) == 0);
      FlushM      = ($urandom_range(7) == 0);
      reset       = ($urandom_range(199) == 0);
      step();
    end
    reset = 0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bp_class_check.md
# bp_class_check

Branch-predictor instruction-class checker for the IFU. It registers the BTB's predicted call/return class from Fetch into Decode and decodes the true call/return class from the Decode instruction. It flags class mispredictions in Decode and pipelines the true class and link address into Execute and Memory. It is the producer side of the return-address-stack protocol: its outputs feed the RAS push, pop-repair and increment/decrement-repair inputs.

## Interface
Parameters:
- XLEN, from config_pkg, datapath/PC width
- CNT_WIDTH, 32, width of the return-misprediction event counter

Ports:
- clk  in  1  clock
- reset  in  1  reset; one clock; reset is asynchronous and active-high
- StallD, StallE, StallM  in  1  pipeline stalls for the D, E and M stages
- FlushD, FlushE, FlushM  in  1  pipeline flushes for the D, E and M stages
- BPReturnF  in  1  BTB predicted the Fetch instruction is a return
- BPCallF  in  1  BTB predicted the Fetch instruction is a call
- InstrD  in  32  Decode instruction, already expanded from the compressed form
- CompressedD  in  1  the Decode instruction was 16-bit originally
- PCD  in  XLEN  PC of the Decode instruction
- ReturnD, CallD  out  1  decoded true class in D (combinational)
- BPReturnWrongD, BPCallWrongD  out  1  predicted class differs from true class
- ReturnE, CallE  out  1  true class in E
- PCLinkE  out  XLEN  link address of the E instruction
- ReturnM, CallM  out  1  true class in M
- ReturnWrongCnt  out  CNT_WIDTH  count of committed return-class mispredictions

## Operation
- Link registers: x1 and x5.
- Class decode uses opcode, rd and rs1:
  - JAL with rd ∈ {x1,x5} is a call.
  - JALR with rd ∈ {x1,x5} is a call, including when rs1 is also a link register. The pop half of a coroutine swap is not modelled.
  - JALR with rd ∉ {x1,x5} and rs1 ∈ {x1,x5} is a return.
  - Everything else is neither. CallD and ReturnD are never both 1.
- BPReturnD and BPCallD are registered from F. BPReturnWrongD = BPReturnD ^ ReturnD; BPCallWrongD = BPCallD ^ CallD.
- PCLinkD = PCD + (CompressedD ? 2 : 4), computed modulo 2^XLEN, so the address wraps at the top of the space. PCLinkD is registered into PCLinkE.
- Stage register rule, applied to every X→Y register (F→D, D→E, E→M):
  - If StallY = 1, the register holds.
  - Otherwise it loads 0 when FlushY = 1, else it loads its D-input.
  - Flush while stalled has no effect.
- ReturnWrongCnt increments by 1 when BPReturnWrongD & ~StallE & ~FlushE. It wraps modulo 2^CNT_WIDTH.

## Timing
- All D outputs are combinational from InstrD, CompressedD, PCD and the F→D registers.
- E outputs appear 1 cycle after the instruction leaves D; M outputs appear 2 cycles after.
- A stall freezes every stage at or before the stalled stage. A stalled D instruction is counted at most once, on the cycle it enters E.
- Reset:
  - asynchronously clears every register: BPReturnD, BPCallD, ReturnE, CallE, PCLinkE, ReturnM, CallM and ReturnWrongCnt all go to 0;
  - D outputs then depend only on InstrD;
  - reset asserted mid-stall discards the held state.
- A flushed slot shows class 0 and link address 0. Bubbles therefore never push or pop the RAS.
- FlushM together with ReturnE is visible on the same cycle through ReturnE. The RAS uses this to undo a speculative pop.

## Structure
- config_pkg supplies XLEN.
- Opcode constants (JAL 7'b1101111, JALR 7'b1100111) and link-register indices belong in the shared bpred package, not local literals.
- One sub-module: bp_class_decode. It holds the combinational InstrD → {CallD, ReturnD} decode, so the BTB class logic can reuse it.
- Stage registers use the codebase's enable/clear flop primitives, with async reset.

## Test plan
- InstrD = jal x1,+8, PCD = 0x1000, CompressedD = 0, no stall → CallD = 1 in D; next edge CallE = 1, PCLinkE = 0x1004; edge after that CallM = 1.
- jalr x0,0(x1) with CompressedD = 1, PCD = 0x2002, previous-cycle BPReturnF = 0 → ReturnD = 1, BPReturnWrongD = 1; next edge ReturnE = 1, PCLinkE = 0x2004, ReturnWrongCnt = 1.
- jalr x5,0(x1) → CallD = 1, ReturnD = 0. jalr x0,0(x6) → both 0. BPCallF = 1 on the prior cycle for the latter → BPCallWrongD = 1.
- Return mispredicted in D with StallE = 1 for 3 cycles, then released → ReturnE stays at its old value during the stall; ReturnWrongCnt rises by exactly 1, on the release edge.
- ReturnD = 1 with FlushE = 1, StallE = 0 → next cycle ReturnE = 0, PCLinkE = 0, counter unchanged. Counter preset to all-ones then one committed miss → counter = 0.
- Assert reset asynchronously mid-pipeline with CallE = 1 and ReturnWrongCnt = 5 → all registered outputs are 0 before the next clock edge.
